// File: rtl/l2p.sv
// l2p: level-to-pulse converter producing one registered strobe per selected edge of d.
// Define L2P_SYNC_EN to put a SYNC_STAGES-deep synchroniser in front of the edge detector.
module l2p #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic ds;
  logic d_q, d_d;
  logic pulse_q, pulse_d;

`ifdef L2P_SYNC_EN
  // Depth is clamped into the legal 2..4 window so a bad override still builds a sane chain.
  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);

  (* ASYNC_REG = "TRUE" *) logic [NSYNC-1:0] sync_q;
  logic [NSYNC-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[NSYNC-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ds = sync_q[NSYNC-1];
`else
  assign ds = d;
`endif

  // Unknown EDGE_MODE values fall back to rising-edge detection.
  always_comb begin
    d_d = ds;
    case (EDGE_MODE)
      1:       pulse_d = ~ds & d_q;
      2:       pulse_d = ds ^ d_q;
      default: pulse_d = ds & ~d_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_q     <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: tb/tb_l2p.sv
// tb_l2p: vector table, latency sequence and randomized run for l2p in all edge modes.
// Builds with or without L2P_SYNC_EN; the reference model follows the same switch.
module tb_l2p;

`ifdef L2P_SYNC_EN
  localparam int NS = 3;
`else
  localparam int NS = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic d;
  logic p0, p1, p2, p3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  l2p #(.SYNC_STAGES(3), .EDGE_MODE(0)) u_m0 (.clk(clk), .reset(reset), .d(d), .pulse(p0));
  l2p #(.SYNC_STAGES(3), .EDGE_MODE(1)) u_m1 (.clk(clk), .reset(reset), .d(d), .pulse(p1));
  l2p #(.SYNC_STAGES(3), .EDGE_MODE(2)) u_m2 (.clk(clk), .reset(reset), .d(d), .pulse(p2));
  l2p #(.SYNC_STAGES(3), .EDGE_MODE(3)) u_m3 (.clk(clk), .reset(reset), .d(d), .pulse(p3));

  typedef struct {
    bit r;
    bit dv;
    bit e_rise;
    bit e_fall;
    bit e_both;
  } vec_t;

  vec_t vecs[$];

  // Reference model: samples of d travel through an NS-deep delay line, then edges are
  // classified against the previous delayed sample.
  bit dq[$];
  bit prev;
  bit m_rise, m_fall, m_both;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    dq = {};
    for (int i = 0; i < NS; i++) dq.push_back(1'b0);
    prev = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit dv);
    bit ds;
    if (!r) begin
      model_reset();
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_both = 1'b0;
    end else begin
      dq.push_back(dv);
      ds = dq.pop_front();
      m_rise = ds && !prev;
      m_fall = !ds && prev;
      m_both = ds != prev;
      prev   = ds;
    end
  endtask

  task automatic cyc(input bit r, input bit dv);
    @(negedge clk);
    reset = r;
    d     = dv;
    @(posedge clk);
    model_step(r, dv);
    #1;
    check("model_rise", p0, m_rise);
    check("model_fall", p1, m_fall);
    check("model_both", p2, m_both);
    check("model_mode3", p3, m_rise);
  endtask

  task automatic add(input bit r, input bit dv, input bit er, input bit ef, input bit eb);
    vec_t v;
    v.r = r; v.dv = dv; v.e_rise = er; v.e_fall = ef; v.e_both = eb;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses;
    reset = 1'b0;
    d     = 1'b0;
    model_reset();

    // held reset with d high, then release with d held high
    add(0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1);
    for (int i = 0; i < 19; i++) add(1, 1, 0, 0, 0);
    // fall after a long high: only falling/both modes see it
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0);
    add(1, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) add(1, 0, 0, 0, 0);
    // toggling every cycle
    for (int i = 0; i < 4; i++) begin
      add(1, 1, 1, 0, 1);
      add(1, 0, 0, 1, 1);
    end
    // reset on the edge that would have pulsed, then release with d high
    add(0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0);
    // release with d low gives nothing
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    // four one-cycle highs separated by three-cycle gaps
    for (int i = 0; i < 4; i++) begin
      add(1, 1, 1, 0, 1);
      add(1, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0);
    end

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].dv);
`ifndef L2P_SYNC_EN
      check("vec_rise", p0, vecs[i].e_rise);
      check("vec_fall", p1, vecs[i].e_fall);
      check("vec_both", p2, vecs[i].e_both);
      check("vec_mode3", p3, vecs[i].e_rise);
`endif
    end

    // latency: d rises before edge k, rising pulse only after edge k+NS
    for (int i = 0; i < NS + 3; i++) cyc(1, 0);
    for (int i = 0; i < NS + 3; i++) begin
      cyc(1, 1);
      check("latency_rise", p0, i == NS);
    end

    // held level for a long time gives exactly one pulse
    for (int i = 0; i < NS + 2; i++) cyc(1, 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 1);
      if (p0) pulses++;
    end
    n_checks++;
    if (pulses == 1) n_pass++;
    else $display("FAIL held_level_count: got %0d pulses expected 1", pulses);

    // randomized run with occasional reset
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) != 0), $urandom_range(0, 1) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
